// File: rtl/lsq_mem_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsq_mem_issue_pkg
// Description : Shared types for the LSQ memory-issue stage: instruction id,
//               load fn3 codes, the in-order load tracker entry and the
//               request-register state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package lsq_mem_issue_pkg;

  localparam int ID_W_DEF = 3;
  typedef logic [ID_W_DEF-1:0] id_t;

  localparam logic [2:0] FN3_LB  = 3'b000;
  localparam logic [2:0] FN3_LH  = 3'b001;
  localparam logic [2:0] FN3_LW  = 3'b010;
  localparam logic [2:0] FN3_LBU = 3'b100;
  localparam logic [2:0] FN3_LHU = 3'b101;

  // One outstanding load: everything needed to format its response later.
  typedef struct packed {
    id_t        id;
    logic [2:0] fn3;
    logic [1:0] byte_off;
  } lsq_tracker_entry_t;

  typedef enum logic [0:0] {
    REQ_IDLE = 1'b0,
    REQ_BUSY = 1'b1
  } req_state_t;

  function automatic logic fn3_legal(input logic [2:0] fn3);
    return fn3 inside {FN3_LB, FN3_LH, FN3_LW, FN3_LBU, FN3_LHU};
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsq_load_formatter.sv
`default_nettype none
// ============================================================================
// Module      : lsq_load_formatter
// Description : Combinational load-result formatter. Selects the byte/half
//               lane from the response word and sign/zero extends by fn3.
//               Unknown fn3 codes pass the whole word through.
// Ports       : rdata_i    - raw response word
//               fn3_i      - access size/sign code
//               byte_off_i - address bits [1:0] of the load
//               result_o   - formatted 32-bit load result
// Revision    : 1.0 - initial release
// ============================================================================
module lsq_load_formatter
  import lsq_mem_issue_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [2:0]  fn3_i,
  input  logic [1:0]  byte_off_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // Halves only look at addr[1]; addr[0] is ignored for half accesses.
    byte_sel = rdata_i[{byte_off_i, 3'b000} +: 8];
    half_sel = rdata_i[{byte_off_i[1], 4'b0000} +: 16];
    result_o = rdata_i;
    case (fn3_i)
      FN3_LB:  result_o = {{24{byte_sel[7]}}, byte_sel};
      FN3_LH:  result_o = {{16{half_sel[15]}}, half_sel};
      FN3_LBU: result_o = {24'h0, byte_sel};
      FN3_LHU: result_o = {16'h0, half_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsq_mem_issue.sv
`default_nettype none
// ============================================================================
// Module      : lsq_mem_issue
// Description : Pops one LSQ entry per cycle into a registered data-memory
//               request held until mem_ack, tracks outstanding loads in
//               order, and formats returning load data into a one-cycle
//               tagged writeback pulse.
// Ports       : clk/rst (async, active-low); lsq_* entry in, lsq_pop out;
//               mem_* request/response; wb_* writeback; idle; rsp_overflow.
// Config      : LSQ_MISALIGN_TRAP_EN - misaligned entries are popped without
//               a memory request and reported on misalign_exc/misalign_id.
// Revision    : 1.0 - initial release
// ============================================================================
module lsq_mem_issue
  import lsq_mem_issue_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ID_W            = 3
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            lsq_valid,
  output logic            lsq_pop,
  input  logic [31:0]     lsq_addr,
  input  logic            lsq_load,
  input  logic            lsq_store,
  input  logic [3:0]      lsq_be,
  input  logic [2:0]      lsq_fn3,
  input  logic [31:0]     lsq_data,
  input  logic [ID_W-1:0] lsq_id,
  output logic            mem_req,
  input  logic            mem_ack,
  output logic            mem_we,
  output logic [31:0]     mem_addr,
  output logic [3:0]      mem_be,
  output logic [31:0]     mem_wdata,
  input  logic            mem_rvalid,
  input  logic [31:0]     mem_rdata,
  output logic            wb_valid,
  output logic [ID_W-1:0] wb_id,
  output logic [31:0]     wb_data,
  output logic            idle,
  output logic            rsp_overflow
`ifdef LSQ_MISALIGN_TRAP_EN
  ,
  output logic            misalign_exc,
  output logic [ID_W-1:0] misalign_id
`endif
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  req_state_t         state_q, state_d;
  logic               mem_we_q;
  logic [31:0]        mem_addr_q, mem_wdata_q;
  logic [3:0]         mem_be_q;

  lsq_tracker_entry_t trk_mem_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_after_rsp;
  lsq_tracker_entry_t push_entry, head_entry;

  logic               wb_valid_q, rsp_overflow_q;
  logic [ID_W-1:0]    wb_id_q;
  logic [31:0]        wb_data_q, fmt_result;

  logic is_store, trk_empty, rsp_pop, can_accept, pop, issue, push, misaligned;

  always_comb begin
    // An entry flagged as both load and store is handled as a load.
    is_store        = lsq_store & ~lsq_load;
    trk_empty       = (count_q == '0);
    rsp_pop         = mem_rvalid & ~trk_empty;
    // A response retiring this cycle frees its slot for a same-cycle load.
    count_after_rsp = count_q - CNT_W'(rsp_pop);
    can_accept      = ((state_q == REQ_IDLE) | mem_ack) &
                      (is_store | (count_after_rsp < CNT_W'(MAX_OUTSTANDING)));
    pop             = lsq_valid & can_accept;
`ifdef LSQ_MISALIGN_TRAP_EN
    misaligned      = ((lsq_fn3[1:0] == 2'b01) & lsq_addr[0]) |
                      (lsq_fn3[1] & (lsq_addr[1:0] != 2'b00));
`else
    misaligned      = 1'b0;
`endif
    issue           = pop & ~misaligned;
    push            = issue & ~is_store;

    push_entry.id       = id_t'(lsq_id);
    push_entry.fn3      = lsq_fn3;
    push_entry.byte_off = lsq_addr[1:0];
    head_entry          = trk_mem_q[rd_ptr_q];

    state_d = state_q;
    if (issue) begin
      state_d = REQ_BUSY;
    end else if (mem_ack) begin
      state_d = REQ_IDLE;
    end
  end

  // Request register: only reloaded when idle or the current request is acked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= REQ_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        mem_we_q    <= is_store;
        mem_addr_q  <= {lsq_addr[31:2], 2'b00};
        mem_be_q    <= is_store ? lsq_be : 4'hF;
        mem_wdata_q <= is_store ? lsq_data : 32'h0;
      end
    end
  end

  // In-order load tracker (circular buffer; pointers wrap naturally).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rsp_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(rsp_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) trk_mem_q[wr_ptr_q] <= push_entry;
  end

  lsq_load_formatter u_fmt (
    .rdata_i    (mem_rdata),
    .fn3_i      (head_entry.fn3),
    .byte_off_i (head_entry.byte_off),
    .result_o   (fmt_result)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid_q     <= 1'b0;
      wb_id_q        <= '0;
      wb_data_q      <= '0;
      rsp_overflow_q <= 1'b0;
    end else begin
      wb_valid_q     <= rsp_pop;
      rsp_overflow_q <= rsp_overflow_q | (mem_rvalid & trk_empty);
      if (rsp_pop) begin
        wb_id_q   <= ID_W'(head_entry.id);
        wb_data_q <= fmt_result;
      end
    end
  end

`ifdef LSQ_MISALIGN_TRAP_EN
  logic            misalign_exc_q;
  logic [ID_W-1:0] misalign_id_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_exc_q <= 1'b0;
      misalign_id_q  <= '0;
    end else begin
      misalign_exc_q <= pop & misaligned;
      if (pop & misaligned) misalign_id_q <= lsq_id;
    end
  end

  assign misalign_exc = misalign_exc_q;
  assign misalign_id  = misalign_id_q;
`endif

  assign lsq_pop      = pop;
  assign mem_req      = (state_q == REQ_BUSY);
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_be       = mem_be_q;
  assign mem_wdata    = mem_wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_id        = wb_id_q;
  assign wb_data      = wb_data_q;
  assign rsp_overflow = rsp_overflow_q;
  assign idle         = (state_q == REQ_IDLE) & trk_empty & ~wb_valid_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst && lsq_valid) begin
      assert (!(lsq_load && lsq_store))
        else $error("lsq_mem_issue: entry marked both load and store");
    end
    if (rst && push) begin
      assert (fn3_legal(lsq_fn3))
        else $error("lsq_mem_issue: load with unsupported fn3 %0b", lsq_fn3);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsq_mem_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsq_mem_issue
// Description : Self-checking bench for lsq_mem_issue: directed scenarios
//               followed by randomized traffic, checked against a queue-based
//               behavioural model of the issue/response rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsq_mem_issue;

  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        lsq_valid = 1'b0, lsq_load = 1'b0, lsq_store = 1'b0;
  logic        lsq_pop;
  logic [31:0] lsq_addr = '0, lsq_data = '0;
  logic [3:0]  lsq_be = '0;
  logic [2:0]  lsq_fn3 = '0, lsq_id = '0;
  logic        mem_req, mem_we, mem_ack = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [3:0]  mem_be;
  logic        wb_valid, idle, rsp_overflow;
  logic [2:0]  wb_id;
  logic [31:0] wb_data;
`ifdef LSQ_MISALIGN_TRAP_EN
  logic        misalign_exc;
  logic [2:0]  misalign_id;
`endif

  always #5 clk = ~clk;

  lsq_mem_issue #(.MAX_OUTSTANDING(MAXO), .ID_W(3)) dut (
    .clk(clk), .rst(rst),
    .lsq_valid(lsq_valid), .lsq_pop(lsq_pop), .lsq_addr(lsq_addr),
    .lsq_load(lsq_load), .lsq_store(lsq_store), .lsq_be(lsq_be),
    .lsq_fn3(lsq_fn3), .lsq_data(lsq_data), .lsq_id(lsq_id),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data),
    .idle(idle), .rsp_overflow(rsp_overflow)
`ifdef LSQ_MISALIGN_TRAP_EN
    , .misalign_exc(misalign_exc), .misalign_id(misalign_id)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [2:0] id;
    logic [2:0] fn3;
    logic [1:0] off;
  } trk_t;

  trk_t        trk_q[$];
  bit          pend_v, pend_we, wb_v, ovf, mexc;
  logic [31:0] pend_addr, pend_wdata, exp_wb_data;
  logic [3:0]  pend_be;
  logic [2:0]  exp_wb_id, mid;

  function automatic logic [31:0] fmt(input logic [31:0] rd, input logic [2:0] f, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[off*8 +: 8];
    h = rd[off[1]*16 +: 16];
    case (f)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return rd;
    endcase
  endfunction

  task automatic model_reset();
    pend_v = 0; wb_v = 0; ovf = 0; mexc = 0;
    trk_q.delete();
  endtask

  task automatic check_regs();
    check_eq("mem_req", mem_req, pend_v);
    if (pend_v) begin
      check_eq("mem_we", mem_we, pend_we);
      check_eq("mem_addr", mem_addr, pend_addr);
      check_eq("mem_be", mem_be, pend_be);
      if (pend_we) check_eq("mem_wdata", mem_wdata, pend_wdata);
    end
    check_eq("wb_valid", wb_valid, wb_v);
    if (wb_v) begin
      check_eq("wb_id", wb_id, exp_wb_id);
      check_eq("wb_data", wb_data, exp_wb_data);
    end
    check_eq("idle", idle, (!pend_v && trk_q.size() == 0 && !wb_v));
    check_eq("rsp_overflow", rsp_overflow, ovf);
`ifdef LSQ_MISALIGN_TRAP_EN
    check_eq("misalign_exc", misalign_exc, mexc);
    if (mexc) check_eq("misalign_id", misalign_id, mid);
`endif
  endtask

  // One clock cycle: drive at negedge, check the combinational pop, advance
  // the model, then check registered outputs at the following negedge.
  task automatic step(input logic v, input logic ld, input logic st,
                      input logic [31:0] a, input logic [3:0] be,
                      input logic [2:0] f, input logic [31:0] d,
                      input logic [2:0] id, input logic ack,
                      input logic rv, input logic [31:0] rd);
    bit   is_st, rsp, exp_pop, mis;
    int   n;
    trk_t e;
    lsq_valid = v; lsq_load = ld; lsq_store = st; lsq_addr = a; lsq_be = be;
    lsq_fn3 = f; lsq_data = d; lsq_id = id; mem_ack = ack; mem_rvalid = rv;
    mem_rdata = rd;
    #1;
    is_st   = st && !ld;
    n       = trk_q.size();
    rsp     = rv && n > 0;
    exp_pop = v && (!pend_v || ack) && (is_st || (n - (rsp ? 1 : 0)) < MAXO);
    check_eq("lsq_pop", lsq_pop, exp_pop);
    if (rv && n == 0) ovf = 1;
    wb_v = rsp;
    if (rsp) begin
      e = trk_q.pop_front();
      exp_wb_id   = e.id;
      exp_wb_data = fmt(rd, e.fn3, e.off);
    end
    mexc = 0;
    if (exp_pop) begin
      mis = 0;
`ifdef LSQ_MISALIGN_TRAP_EN
      mis = (f[1:0] == 2'b01 && a[0]) || (f[1] && a[1:0] != 2'b00);
`endif
      if (mis) begin
        pend_v = 0; mexc = 1; mid = id;
      end else begin
        pend_v = 1; pend_we = is_st; pend_addr = {a[31:2], 2'b00};
        pend_be = is_st ? be : 4'hF; pend_wdata = d;
        if (!is_st) begin
          e.id = id; e.fn3 = f; e.off = a[1:0];
          trk_q.push_back(e);
        end
      end
    end else if (ack) begin
      pend_v = 0;
    end
    @(posedge clk);
    @(negedge clk);
    check_regs();
  endtask

  task automatic idle_step(input logic ack, input logic rv, input logic [31:0] rd);
    step(0, 0, 0, 32'h0, 4'h0, 3'b0, 32'h0, 3'd0, ack, rv, rd);
  endtask

  logic [2:0] legal_fn3 [5];

  initial begin
    legal_fn3[0] = 3'b000; legal_fn3[1] = 3'b001; legal_fn3[2] = 3'b010;
    legal_fn3[3] = 3'b100; legal_fn3[4] = 3'b101;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_wb_valid", wb_valid, 0);
    check_eq("rst_ovf", rsp_overflow, 0);
    check_eq("rst_idle", idle, 1);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_be", mem_be, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_wb_id", wb_id, 0);
    check_eq("rst_wb_data", wb_data, 0);
    rst = 1'b1;

    // Store held for 4 cycles without ack
    step(1, 0, 1, 32'h1002, 4'b1100, 3'b010, 32'hABCD0000, 3'd0, 0, 0, 0);
    repeat (3) step(1, 0, 1, 32'h5000, 4'h3, 3'b010, 32'h1111, 3'd0, 0, 0, 0);
    check_eq("st_hold_addr", mem_addr, 32'h1000);
    idle_step(1, 0, 0);

    // LB sign-extended from lane 3
    step(1, 1, 0, 32'h2003, 4'h0, 3'b000, 32'h0, 3'd5, 0, 0, 0);
    idle_step(1, 0, 0);
    idle_step(0, 1, 32'h80112233);
    check_eq("lb_id", wb_id, 5);
    check_eq("lb_data", wb_data, 32'hFFFFFF80);
    idle_step(0, 0, 0);

    // Back-to-back LHU / LW
    step(1, 1, 0, 32'h10, 4'h0, 3'b101, 32'h0, 3'd1, 0, 0, 0);
    step(1, 1, 0, 32'h14, 4'h0, 3'b010, 32'h0, 3'd2, 1, 0, 0);
    idle_step(1, 0, 0);
    idle_step(0, 1, 32'h0000BEEF);
    check_eq("lhu_data", wb_data, 32'h0000BEEF);
    idle_step(0, 1, 32'h12345678);
    check_eq("lw_id", wb_id, 2);

    // Tracker full: fifth load blocked, store passes, response frees a slot
    for (int i = 0; i < 4; i++)
      step(1, 1, 0, 32'h100 + 32'(i * 4), 4'h0, 3'b010, 32'h0, 3'(i), 1, 0, 0);
    step(1, 1, 0, 32'h200, 4'h0, 3'b010, 32'h0, 3'd4, 1, 0, 0);
    step(1, 0, 1, 32'h300, 4'hF, 3'b010, 32'hCAFEF00D, 3'd0, 0, 0, 0);
    step(1, 1, 0, 32'h200, 4'h0, 3'b010, 32'h0, 3'd4, 1, 1, 32'h11110000);
    idle_step(1, 0, 0);
    repeat (4) idle_step(0, 1, $urandom);
    idle_step(0, 0, 0);

    // Response with empty tracker sets sticky overflow; async reset clears
    idle_step(0, 1, 32'hDEAD0000);
    idle_step(0, 0, 0);
    check_eq("ovf_sticky", rsp_overflow, 1);
    #2 rst = 1'b0;
    #1 check_eq("ovf_async_clr", rsp_overflow, 0);
    check_eq("rst_idle2", idle, 1);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      logic st, rv;
      st = ($urandom % 10) < 4;
      rv = (trk_q.size() > 0) ? 1'($urandom % 2) : (($urandom % 60) == 0);
      step(($urandom % 10) < 7, !st, st, $urandom, 4'($urandom),
           st ? 3'($urandom) : legal_fn3[$urandom % 5], $urandom,
           3'($urandom), ($urandom % 10) < 6, rv, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
